seq_mult_16: RTL and testbench

Iterative unsigned shift-and-add multiplier. Takes two 16-bit operands on a `start` pulse and produces a 32-bit product after a fixed 16-cycle latency. Sits directly upstream of the datapath's 32-bit result register: `product` drives that register's data input, and `done` tells the control logic which cycle to capture it. One multiply in flight at a time; `start`/`busy`/`done` handshake.

---
 rtl/seq_mult_16.sv | 71 +++++++
 tb/tb_seq_mult_16.sv | 111 +++++++++++
 2 files changed

// File: rtl/seq_mult_16.sv
// seq_mult_16: iterative unsigned shift-and-add multiplier, fixed WIDTH-cycle latency
module seq_mult_16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, prod_q, prod_d, sum;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [4:0] cnt_q, cnt_d;
  logic done_q, done_d;
  always_comb begin
    sum      = mplier_q[0] ? acc_q + mcand_q : acc_q;
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = BUSY;
      end
    end else begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'(WIDTH - 1)) begin
        prod_d  = sum;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
    end
  end
  assign busy    = (state_q == BUSY);
  assign done    = done_q;
  assign product = prod_q;
endmodule

// File: tb/tb_seq_mult_16.sv
// tb_seq_mult_16: directed tests of seq_mult_16 against a cycle-level behavioural model
module tb_seq_mult_16;
  logic clk = 0, reset = 0, start = 0;
  logic [15:0] a = 0, b = 0;
  logic busy, done;
  logic [31:0] product;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  bit m_busy = 0, m_done = 0;
  int m_left = 0;
  logic [31:0] m_prod = 0, m_pend = 0;

  always #5 clk = ~clk;

  seq_mult_16 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  // Model: a multiply takes 16 edges after acceptance; only the finishing edge publishes a*b.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_left = 0; m_prod = 0; m_pend = 0;
    end else begin
      bit was_busy;
      was_busy = m_busy;
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_prod = m_pend;
        end
      end
      if (!was_busy && start) begin
        m_pend = 32'(a) * 32'(b);
        m_left = 16;
        m_busy = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("product", product, m_prod);
  end

  task automatic start_op(input logic [15:0] x, input logic [15:0] y);
    start = 1; a = x; b = y;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp, input int ign_at, input bit toggle);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (toggle) begin a = 16'($urandom); b = 16'($urandom); end
      if (n == ign_at) begin start = 1; a = 16'h0F0F; b = 16'h00F0; end
      else start = 0;
      @(negedge clk);
      n++;
    end
    start = 0;
    chk({name, "_latency"}, 32'(n), 32'd16);
    chk({name, "_product"}, product, exp);
  endtask

  initial begin
    int d;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_product", product, 32'd0);
    reset = 1;
    @(negedge clk);
    start_op(16'd3, 16'd5);           wait_done("3x5", 32'h0000000F, -1, 0);
    start_op(16'hFFFF, 16'hFFFF);     wait_done("max", 32'hFFFE0001, -1, 0);
    start_op(16'h1234, 16'h0000);     wait_done("zero", 32'h00000000, -1, 0);
    start_op(16'h00FF, 16'h0100);     wait_done("b2b_1", 32'h0000FF00, -1, 0);
    start_op(16'h8000, 16'h0002);     wait_done("b2b_2", 32'h00010000, -1, 0);
    repeat (2) @(negedge clk);
    start_op(16'd3, 16'd4);           wait_done("ignore", 32'h0000000C, 5, 0);
    d = 0;
    repeat (20) begin @(negedge clk); if (done) d++; end
    chk("no_extra_done", 32'(d), 32'd0);
    start_op(16'h1234, 16'h5678);
    repeat (8) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_product", product, 32'd0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    start_op(16'd7, 16'd9);           wait_done("after_abort", 32'h0000003F, -1, 0);
    start_op(16'hABCD, 16'h0011);     wait_done("toggle", 32'h000B689D, -1, 1);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
